step_pulse_decoder: RTL and testbench
=====================================

Name: step_pulse_decoder

Overview:
Receive-side counterpart of the divisor-based step-pulse generator. Decodes an incoming step/direction pulse train, for example a driver encoder-echo or a loopback of pulse_out/direction, into a signed position count and a pulse-period measurement. On each sampling strobe it presents a coherent snapshot so the DSP reads position and velocity from the same instant. Sits between the driver-side LVDS inputs and the dual-port RAM / DSP register map.

Parameters:
CNT_W, 32, width of signed position counter and snapshot
PERIOD_W, 32, width of period counter and period outputs
TIMEOUT, 18750000, clk cycles without a step edge before declaring stall (1 s at 18.75 MHz); must be < 2^PERIOD_W
SYNC_STAGES, 2, synchronizer flops on pulse_in and dir_in
FILT, 3, consecutive synchronized samples needed to accept a level change on pulse_in

Ports:
clk  in  1  system clock; sole clock domain
rst  in  1  synchronous, active-high reset
pulse_in  in  1  asynchronous step pulse; a rising edge is one step
dir_in  in  1  asynchronous direction; 1 = +1 per step, 0 = -1 per step
sample  in  1  clk-domain sampling clock (clock_divisor output); its rising edge takes a snapshot
clear_pos  in  1  one-cycle request to zero position
position  out  CNT_W  live signed step count
period  out  PERIOD_W  clk cycles between the last two accepted step edges; 0 while stalled
stalled  out  1  no step edge within TIMEOUT cycles, or no period reference yet
snap_position  out  CNT_W  position captured at sample rise
snap_period  out  PERIOD_W  period captured at sample rise
snap_valid  out  1  one-cycle pulse when snapshot registers update

Behaviour:
- Reset, synchronous, active-high:
  - position, period, snap_position, snap_period, snap_valid: 0
  - stalled: 1; FSM: ST_STALL; filtered level: 0
  - synchronizer, filter counter, period counter, sample delay flop: 0
- Input path:
  - pulse_in and dir_in each pass through SYNC_STAGES flops.
  - The filtered level flips only after the synchronized pulse_in differs from it for FILT consecutive cycles. Any agreeing cycle clears the filter counter.
  - A step edge is a 0->1 transition of the filtered level.
- Latency: with defaults, position changes 6 clk edges (SYNC_STAGES+FILT+1) after the first clk edge that samples pulse_in high. Pulses shorter than FILT cycles at the synchronizer output are discarded.
- Position:
  - On a step edge, add +1 if synchronized dir_in is 1, else -1.
  - Two's-complement wrap with no saturation: 0x7FFFFFFF+1 gives 0x80000000, and 0-1 gives 0xFFFFFFFF.
  - clear_pos sets position to 0. If clear_pos and a step edge occur in the same cycle, clear wins and the step is lost.
- Period FSM:
  - ST_STALL + step edge -> ST_RUN. Period counter set to 0; period stays 0; stalled stays 1.
  - ST_RUN + step edge: period <= counter+1, counter <= 0, stalled <= 0.
  - ST_RUN, no edge: counter increments. When counter+1 reaches TIMEOUT, go to ST_STALL with period <= 0 and stalled <= 1.
  - If an edge and the timeout fall in the same cycle, the edge wins.
  - The period counter saturates and never wraps.
- Snapshot:
  - A sample rise is sample high while the registered sample was low.
  - In the cycle after the rise is detected, snap_position and snap_period load the values that held in the detect cycle. snap_valid is high for exactly that one cycle.
  - If sample rises in the same cycle as clear_pos or a step edge, the snapshot gets the pre-update value.
- rst mid-operation discards any in-flight filter state, edge or snapshot. No snap_valid pulse is emitted for a sample rise that coincides with rst.

Decomposition:
- Shared package step_decoder_pkg:
  - FSM enum {ST_STALL, ST_RUN}
  - default constants TIMEOUT_1S = 18750000, FILT_DEFAULT = 3, SYNC_DEFAULT = 2
- Sub-module pulse_input_filter: synchronizer + FILT glitch filter + rising-edge output. Instantiate it for pulse_in. dir_in uses only a plain synchronizer.

Test Plan:
- Reset check: rst high 3 cycles -> position=0, period=0, stalled=1, snap_valid=0, all stable while no input toggles.
- Forward steps: dir_in=1, 10 pulses high 8 / low 8 cycles -> position=10; after 2nd edge period=16, stalled=0; first accepted edge at cycle 6 after pulse_in rises.
- Reverse and wrap: from position 10 with dir_in=0, 3 pulses -> position=7. After clear_pos, one reverse pulse -> position=0xFFFFFFFF.
- Glitch filter: pulse_in high 2 cycles -> no position change. High 3 cycles -> exactly +1.
- Timeout (TIMEOUT=1000): stop pulses after a 16-cycle train -> stalled=1 and period=0 exactly 1000 cycles after the last accepted edge. The next single edge leaves period=0 and stalled=1; the following edge 20 cycles later gives period=20.
- Snapshot collision: position=5, sample rise in the same cycle as clear_pos -> next cycle snap_position=5, position=0, snap_valid high exactly 1 cycle.

Source files
------------

// File: rtl/step_decoder_pkg.sv
// Shared types and default constants for the step/direction pulse decoder.
package step_decoder_pkg;

    typedef enum logic {
        ST_STALL = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int unsigned TIMEOUT_1S   = 18750000;
    localparam int unsigned FILT_DEFAULT = 3;
    localparam int unsigned SYNC_DEFAULT = 2;

endpackage

// File: rtl/pulse_input_filter.sv
// Synchronizes an asynchronous pulse input, rejects glitches shorter than FILT
// cycles and emits a one-cycle pulse on each accepted 0->1 level change.
module pulse_input_filter
    import step_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_DEFAULT,
    parameter int unsigned FILT        = FILT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    localparam int unsigned FC_W = (FILT > 1) ? $clog2(FILT) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FC_W-1:0]        r_fcnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   w_sync;
    logic                   w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_sync != r_level) && (r_fcnt == FC_W'(FILT - 1));
    assign o_rise   = r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Level only flips after FILT consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= w_accept & ~r_level;
            if (w_sync == r_level) begin
                r_fcnt <= '0;
            end else if (w_accept) begin
                r_level <= w_sync;
                r_fcnt  <= '0;
            end else begin
                r_fcnt <= r_fcnt + FC_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_pulse_decoder.sv
// Decodes a step/direction pulse train into a signed position and a step
// period, with a coherent snapshot of both taken on each sample rise.
module step_pulse_decoder
    import step_decoder_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PERIOD_W    = 32,
    parameter int unsigned TIMEOUT     = TIMEOUT_1S,
    parameter int unsigned SYNC_STAGES = SYNC_DEFAULT,
    parameter int unsigned FILT        = FILT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pulse_in,
    input  logic                i_dir_in,
    input  logic                i_sample,
    input  logic                i_clear_pos,
    output logic [CNT_W-1:0]    o_position,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_stalled,
    output logic [CNT_W-1:0]    o_snap_position,
    output logic [PERIOD_W-1:0] o_snap_period,
    output logic                o_snap_valid
);

    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic                   w_dir;
    logic                   w_step;

    logic [CNT_W-1:0]       r_position;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PERIOD_W-1:0]    r_pcnt;
    logic [PERIOD_W-1:0]    w_pcnt_next;
    logic [PERIOD_W-1:0]    w_pcnt_inc;
    logic [PERIOD_W-1:0]    r_period;
    logic [PERIOD_W-1:0]    w_period_next;
    logic                   r_stalled;
    logic                   w_stalled_next;

    logic                   r_sample_d;
    logic                   w_sample_rise;
    logic [CNT_W-1:0]       r_snap_position;
    logic [PERIOD_W-1:0]    r_snap_period;
    logic                   r_snap_valid;

    pulse_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT        (FILT)
    ) u_pulse_filter (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_pulse_in),
        .o_rise  (w_step)
    );

    assign w_dir = r_dir_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir_sync <= '0;
        end else begin
            r_dir_sync[0] <= i_dir_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_dir_sync[i] <= r_dir_sync[i-1];
            end
        end
    end

    // Clear takes priority over a coincident step; wraps without saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_position <= '0;
        end else if (i_clear_pos) begin
            r_position <= '0;
        end else if (w_step) begin
            r_position <= r_position + (w_dir ? CNT_W'(1) : {CNT_W{1'b1}});
        end
    end

    assign w_pcnt_inc = (r_pcnt == {PERIOD_W{1'b1}}) ? r_pcnt : r_pcnt + PERIOD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_STALL;
            r_pcnt    <= '0;
            r_period  <= '0;
            r_stalled <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_pcnt    <= w_pcnt_next;
            r_period  <= w_period_next;
            r_stalled <= w_stalled_next;
        end
    end

    // A step edge wins over a timeout landing in the same cycle.
    always_comb begin
        w_state_next   = r_state;
        w_pcnt_next    = r_pcnt;
        w_period_next  = r_period;
        w_stalled_next = r_stalled;
        case (r_state)
            ST_STALL: begin
                if (w_step) begin
                    w_state_next = ST_RUN;
                    w_pcnt_next  = '0;
                end
            end
            ST_RUN: begin
                if (w_step) begin
                    w_period_next  = w_pcnt_inc;
                    w_pcnt_next    = '0;
                    w_stalled_next = 1'b0;
                end else if (w_pcnt_inc >= PERIOD_W'(TIMEOUT)) begin
                    w_state_next   = ST_STALL;
                    w_pcnt_next    = '0;
                    w_period_next  = '0;
                    w_stalled_next = 1'b1;
                end else begin
                    w_pcnt_next = w_pcnt_inc;
                end
            end
            default: begin
                w_state_next = ST_STALL;
            end
        endcase
    end

    assign w_sample_rise = i_sample & ~r_sample_d;

    // Snapshot captures the pre-update live values of the detect cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_d      <= 1'b0;
            r_snap_valid    <= 1'b0;
            r_snap_position <= '0;
            r_snap_period   <= '0;
        end else begin
            r_sample_d   <= i_sample;
            r_snap_valid <= w_sample_rise;
            if (w_sample_rise) begin
                r_snap_position <= r_position;
                r_snap_period   <= r_period;
            end
        end
    end

    assign o_position      = r_position;
    assign o_period        = r_period;
    assign o_stalled       = r_stalled;
    assign o_snap_position = r_snap_position;
    assign o_snap_period   = r_snap_period;
    assign o_snap_valid    = r_snap_valid;

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Bench for step_pulse_decoder: pulse-train vector table plus hand sequences
// for latency, clear collisions, snapshots and timeout.
module tb_step_pulse_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_in;
    logic        dir_in;
    logic        sample;
    logic        clear_pos;
    logic [31:0] position;
    logic [31:0] period;
    logic        stalled;
    logic [31:0] snap_position;
    logic [31:0] snap_period;
    logic        snap_valid;

    int checks = 0;
    int errors = 0;
    int snap_pulses = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        string       name;
        int          n;
        int          hi;
        int          lo;
        logic        dir;
        logic [31:0] exp_pos;
        logic [31:0] exp_period;
        logic        exp_stalled;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    step_pulse_decoder #(
        .CNT_W       (32),
        .PERIOD_W    (32),
        .TIMEOUT     (1000),
        .SYNC_STAGES (2),
        .FILT        (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_pulse_in      (pulse_in),
        .i_dir_in        (dir_in),
        .i_sample        (sample),
        .i_clear_pos     (clear_pos),
        .o_position      (position),
        .o_period        (period),
        .o_stalled       (stalled),
        .o_snap_position (snap_position),
        .o_snap_period   (snap_period),
        .o_snap_valid    (snap_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        repeat (hi) step_clk();
        pulse_in = 1'b0;
        repeat (lo) step_clk();
    endtask

    // Snapshot scoreboard: every snap_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (snap_valid === 1'b1) begin
            logic [63:0] exp;
            snap_pulses++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL snap_unexpected: got pos 0x%08h per %0d with no expected snapshot at %0t",
                         snap_position, snap_period, $time);
            end else begin
                exp = sb_q.pop_front();
                if ({snap_position, snap_period} !== exp) begin
                    errors++;
                    $display("FAIL snap_value: got pos 0x%08h per %0d expected pos 0x%08h per %0d at %0t",
                             snap_position, snap_period, exp[63:32], exp[31:0], $time);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{"fwd_second_edge", 1, 8, 8, 1'b1, 32'd2, 32'd16, 1'b0};
        vecs[1] = '{"fwd_train",       8, 8, 8, 1'b1, 32'd10, 32'd16, 1'b0};
        vecs[2] = '{"reverse",         3, 8, 8, 1'b0, 32'd7, 32'd16, 1'b0};
        vecs[3] = '{"fwd_duty_5_11",   3, 5, 11, 1'b1, 32'd10, 32'd16, 1'b0};
        vecs[4] = '{"fwd_period_20",   4, 10, 10, 1'b1, 32'd14, 32'd20, 1'b0};
        vecs[5] = '{"glitch_2",        1, 2, 14, 1'b1, 32'd14, 32'd20, 1'b0};
        vecs[6] = '{"accept_3",        1, 3, 13, 1'b1, 32'd15, 32'd36, 1'b0};

        rst = 1'b1; pulse_in = 1'b0; dir_in = 1'b1; sample = 1'b0; clear_pos = 1'b0;
        repeat (3) step_clk();
        chk("reset_position", position, 32'd0);
        chk("reset_period", period, 32'd0);
        chk("reset_stalled", 32'(stalled), 32'd1);
        chk("reset_snap_valid", 32'(snap_valid), 32'd0);

        rst = 1'b0;
        repeat (5) step_clk();
        chk("idle_position", position, 32'd0);
        chk("idle_stalled", 32'(stalled), 32'd1);

        // First pulse: position moves on the 6th edge after pulse_in is sampled high.
        pulse_in = 1'b1;
        repeat (5) step_clk();
        chk("latency_before", position, 32'd0);
        step_clk();
        chk("latency_edge", position, 32'd1);
        repeat (2) step_clk();
        pulse_in = 1'b0;
        repeat (8) step_clk();
        chk("first_edge_period", period, 32'd0);
        chk("first_edge_stalled", 32'(stalled), 32'd1);

        for (int v = 0; v < 7; v++) begin
            dir_in = vecs[v].dir;
            for (int p = 0; p < vecs[v].n; p++) pulse(vecs[v].hi, vecs[v].lo);
            chk({vecs[v].name, "_pos"}, position, vecs[v].exp_pos);
            chk({vecs[v].name, "_period"}, period, vecs[v].exp_period);
            chk({vecs[v].name, "_stalled"}, 32'(stalled), 32'(vecs[v].exp_stalled));
        end

        clear_pos = 1'b1;
        step_clk();
        clear_pos = 1'b0;
        chk("clear_pos", position, 32'd0);
        dir_in = 1'b0;
        pulse(8, 8);
        chk("wrap_below_zero", position, 32'hFFFF_FFFF);
        dir_in = 1'b1;
        pulse(8, 8);
        chk("wrap_back_to_zero", position, 32'd0);
        pulse(8, 8);
        chk("fwd_to_one", position, 32'd1);

        // clear_pos coinciding with a step edge: the step is lost.
        pulse_in = 1'b1;
        repeat (5) step_clk();
        clear_pos = 1'b1;
        step_clk();
        clear_pos = 1'b0;
        chk("clear_beats_step", position, 32'd0);
        repeat (2) step_clk();
        pulse_in = 1'b0;
        repeat (8) step_clk();
        chk("clear_beats_step_after", position, 32'd0);

        for (int p = 0; p < 5; p++) pulse(8, 8);
        chk("pre_snap_pos", position, 32'd5);

        // Sample rise together with clear_pos: snapshot sees the old position.
        sample = 1'b1;
        clear_pos = 1'b1;
        sb_q.push_back({32'd5, 32'd16});
        step_clk();
        clear_pos = 1'b0;
        chk("snap_collision_pos_live", position, 32'd0);
        chk("snap_collision_valid", 32'(snap_valid), 32'd1);
        chk("snap_collision_snap_pos", snap_position, 32'd5);
        step_clk();
        chk("snap_valid_one_cycle", 32'(snap_valid), 32'd0);
        sample = 1'b0;
        step_clk();

        // Sample rise in the same cycle as a step edge.
        pulse_in = 1'b1;
        repeat (5) step_clk();
        sample = 1'b1;
        sb_q.push_back({32'd0, 32'd16});
        step_clk();
        chk("snap_at_edge_live", position, 32'd1);
        sample = 1'b0;
        step_clk();
        pulse_in = 1'b0;
        repeat (8) step_clk();

        // Timeout: stall exactly 1000 cycles after the last accepted edge.
        for (int p = 0; p < 3; p++) pulse(8, 8);
        chk("train_pos", position, 32'd4);
        chk("train_period", period, 32'd16);
        repeat (989) step_clk();
        chk("timeout_minus1_stalled", 32'(stalled), 32'd0);
        chk("timeout_minus1_period", period, 32'd16);
        step_clk();
        chk("timeout_stalled", 32'(stalled), 32'd1);
        chk("timeout_period", period, 32'd0);

        sample = 1'b1;
        sb_q.push_back({32'd4, 32'd0});
        step_clk();
        sample = 1'b0;
        step_clk();

        pulse(8, 12);
        chk("restart_edge_period", period, 32'd0);
        chk("restart_edge_stalled", 32'(stalled), 32'd1);
        pulse(8, 8);
        chk("restart_period", period, 32'd20);
        chk("restart_stalled", 32'(stalled), 32'd0);
        chk("restart_pos", position, 32'd6);

        // Sample rise coinciding with rst produces no snapshot.
        sample = 1'b1;
        rst = 1'b1;
        step_clk();
        sample = 1'b0;
        repeat (2) step_clk();
        rst = 1'b0;
        repeat (3) step_clk();
        chk("midrst_position", position, 32'd0);
        chk("midrst_stalled", 32'(stalled), 32'd1);

        chk("snap_pulse_count", 32'(snap_pulses), 32'd3);
        chk("snap_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
